// File: rtl/ahb_lite_sram_slave_pkg.sv
// rtl/ahb_lite_sram_slave_pkg.sv - bus encodings, slave FSM states and byte-lane helper
package ahb_lite_sram_slave_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  // Little-endian lane mask; alignment is already guaranteed by the error decode.
  function automatic logic [WORD_BYTES-1:0] lane_enable(input logic [2:0] size,
                                                         input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: lane_enable = 4'b0001 << lo;
      HSIZE_HALF: lane_enable = lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// rtl/ahb_sram_bytemem.sv - word-organised SRAM with per-byte write enables and async read
module ahb_sram_bytemem
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic [IDX_W-1:0]        addr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  output logic [8*WORD_BYTES-1:0] rdata
);

  // No reset: contents must survive a bus reset.
  logic [8*WORD_BYTES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-lite slave fronting a byte-addressable SRAM
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP,
  output logic                  HREADY
);

  localparam int                    IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [2:0]            WAIT_INIT   = 3'(WAIT_STATES);

  slave_state_e          state_q, state_d;
  logic [2:0]            wait_q, wait_d;
  logic                  pending_q, pending_d;
  logic [IDX_W+1:0]      addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  accept;
  logic                  addr_err;
  logic                  commit;
  logic [WORD_BYTES-1:0] lane_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Burst type, protection and the SEQ/NONSEQ distinction do not change behaviour.
  wire unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign HREADY = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign accept = HREADY && HSEL && HTRANS[1];

  always_comb begin
    addr_err = 1'b0;
    if (HADDR[ADDR_WIDTH-1:2] >= DEPTH_WORDS) addr_err = 1'b1;
    case (HSIZE)
      HSIZE_BYTE: ;
      HSIZE_HALF: if (HADDR[0]) addr_err = 1'b1;
      HSIZE_WORD: if (HADDR[1:0] != 2'b00) addr_err = 1'b1;
      default:    addr_err = 1'b1;
    endcase
  end

  // pending_q marks an OKAY data phase in flight; IDLE with pending_q set is its completion cycle.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pending_d = pending_q;
    if (HREADY) pending_d = accept && !addr_err;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q <= 3'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      if (accept) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  assign commit  = (state_q == ST_IDLE) && pending_q && write_q;
  assign lane_be = lane_enable(size_q, addr_q[1:0]);

  // Read path uses the registered address so a write completing on the previous edge is visible.
  ahb_sram_bytemem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (commit),
    .be    (lane_be),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA = ((state_q == ST_IDLE) && pending_q && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - self-checking bench: vector table, corner sequences, random vs byte model
module tb_ahb_lite_sram_slave;

  localparam int NDUT  = 3;
  localparam int MAXQ  = 8;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst_n, hsel, hwrite;
  logic [1:0]      htrans [NDUT];
  logic [2:0]      hsize  [NDUT];
  logic [2:0]      hburst [NDUT];
  logic [3:0]      hprot  [NDUT];
  logic [31:0]     haddr  [NDUT];
  logic [31:0]     hwdata [NDUT];
  wire  [NDUT-1:0] hready, hresp;
  wire  [31:0]     hrdata [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_lite_sram_slave #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_DEPTH   (256),
      .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk     (clk),
      .HRESETn (rst_n[g]),
      .HSEL    (hsel[g]),
      .HADDR   (haddr[g]),
      .HWRITE  (hwrite[g]),
      .HTRANS  (htrans[g]),
      .HSIZE   (hsize[g]),
      .HBURST  (hburst[g]),
      .HPROT   (hprot[g]),
      .HWDATA  (hwdata[g]),
      .HRDATA  (hrdata[g]),
      .HRESP   (hresp[g]),
      .HREADY  (hready[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transfer queue for one back-to-back run and what the bus showed for each entry.
  int          sq_n;
  logic        sq_wr    [MAXQ];
  logic [2:0]  sq_size  [MAXQ];
  logic [31:0] sq_addr  [MAXQ];
  logic [31:0] sq_wdata [MAXQ];
  logic [1:0]  sq_trans [MAXQ];
  int          r_low      [MAXQ];
  logic        r_resp_low [MAXQ];
  logic        r_resp     [MAXQ];
  logic        r_bad      [MAXQ];
  logic [31:0] r_rdata    [MAXQ];

  task automatic push_xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] trans);
    sq_wr[sq_n]    = wr;
    sq_size[sq_n]  = size;
    sq_addr[sq_n]  = addr;
    sq_wdata[sq_n] = wdata;
    sq_trans[sq_n] = trans;
    sq_n++;
  endtask

  task automatic drive_addr(input int k, input int i);
    hsel[k]   = 1'b1;
    htrans[k] = sq_trans[i];
    hwrite[k] = sq_wr[i];
    hsize[k]  = sq_size[i];
    haddr[k]  = sq_addr[i];
    hburst[k] = 3'($urandom);
    hprot[k]  = 4'($urandom);
  endtask

  task automatic drive_idle(input int k);
    hsel[k]   = 1'b0;
    htrans[k] = 2'b00;
    hwrite[k] = 1'b0;
    haddr[k]  = 32'h0;
  endtask

  // Master: issues the queue with each address phase overlapping the previous data phase.
  task automatic run_seq(input int k);
    int cur, nxt, cyc;
    logic hr, rp;
    logic [31:0] rd;
    cur = -1;
    nxt = 0;
    cyc = 0;
    for (int i = 0; i < sq_n; i++) begin
      r_low[i] = 0; r_resp_low[i] = 1'b0; r_resp[i] = 1'b0; r_bad[i] = 1'b0; r_rdata[i] = 32'h0;
    end
    drive_addr(k, 0);
    while ((cur >= 0 || nxt < sq_n) && cyc < BOUND) begin
      @(negedge clk);
      hr = hready[k]; rp = hresp[k]; rd = hrdata[k];
      cyc++;
      if (cur >= 0) begin
        if (!hr) begin
          r_low[cur]++;
          r_resp_low[cur] = rp;
          if (rd !== 32'h0) r_bad[cur] = 1'b1;
        end else begin
          r_resp[cur]  = rp;
          r_rdata[cur] = rd;
        end
      end
      @(posedge clk);
      #1;
      if (hr) begin
        if (nxt < sq_n) begin
          cur = nxt;
          nxt++;
        end else begin
          cur = -1;
        end
        if (nxt < sq_n) drive_addr(k, nxt);
        else drive_idle(k);
        if (cur >= 0) hwdata[k] = sq_wdata[cur];
      end
    end
    check($sformatf("dut%0d.seq_timeout", k), 32'(cyc >= BOUND), 32'h0);
  endtask

  // Reference: flat byte array per DUT, transfers applied in issue order.
  logic [7:0] mdl [NDUT][1024];

  task automatic model_xfer(input int k, input logic wr, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int low, output logic resp, output logic [31:0] rdata);
    int a, base;
    bit err;
    err = (addr >= 32'd1024) || (size > 3'd2) || (size == 3'd1 && addr[0]) ||
          (size == 3'd2 && addr[1:0] != 2'b00);
    low   = err ? 1 : ws_of(k);
    resp  = err;
    rdata = 32'h0;
    if (!err) begin
      a    = int'(addr);
      base = a - (a % 4);
      if (wr) begin
        for (int j = 0; j < (1 << size); j++) mdl[k][a+j] = wdata[8*((a+j)%4) +: 8];
      end else begin
        rdata = {mdl[k][base+3], mdl[k][base+2], mdl[k][base+1], mdl[k][base]};
      end
    end
  endtask

  task automatic verify(input string tag, input int i, input int low, input logic resp,
                        input logic [31:0] rdata);
    check({tag, ".wait_cycles"}, 32'(r_low[i]), 32'(low));
    check({tag, ".hresp_done"}, 32'(r_resp[i]), 32'(resp));
    if (low > 0) check({tag, ".hresp_wait"}, 32'(r_resp_low[i]), 32'(resp));
    check({tag, ".hrdata"}, r_rdata[i], rdata);
    check({tag, ".hrdata_zero_while_low"}, 32'(r_bad[i]), 32'h0);
  endtask

  task automatic run_model_check(input int k, input string tag);
    int low;
    logic resp;
    logic [31:0] rdata;
    run_seq(k);
    for (int i = 0; i < sq_n; i++) begin
      model_xfer(k, sq_wr[i], sq_size[i], sq_addr[i], sq_wdata[i], low, resp, rdata);
      verify($sformatf("%s.x%0d", tag, i), i, low, resp, rdata);
    end
    sq_n = 0;
  endtask

  typedef struct {
    int          k;
    bit          wr;
    int          size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          b2b;
    int          low;
    bit          resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int k, input bit wr, input int size, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit b2b, input int low,
                              input bit resp, input logic [31:0] rdata);
    vec_t v;
    v.k = k; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.b2b = b2b; v.low = low; v.resp = resp; v.rdata = rdata;
    return v;
  endfunction

  int          vi, vj, dlow, gsel, nx;
  logic        dresp;
  logic [31:0] drd, raddr;
  logic [2:0]  rsize;

  initial begin
    // DUT0: WAIT_STATES=0, DUT1: 1, DUT2: 3. b2b chains an entry to the next one.
    tbl.push_back(mk(1, 1, 2, 32'h010, 32'hDEADBEEF, 0, 1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 32'h010, 32'h0,        0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 2, 32'h020, 32'h11223344, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h020, 32'h0,        0, 0, 0, 32'h11223344));
    tbl.push_back(mk(0, 1, 0, 32'h021, 32'h0000AA00, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h022, 32'hBBCC0000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h020, 32'h0,        0, 0, 0, 32'hBBCCAA44));
    tbl.push_back(mk(0, 0, 2, 32'h400, 32'h0,        1, 1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h020, 32'h0,        0, 0, 0, 32'hBBCCAA44));
    tbl.push_back(mk(0, 1, 2, 32'h022, 32'h55555555, 0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h020, 32'h0,        0, 0, 0, 32'hBBCCAA44));
    tbl.push_back(mk(2, 1, 2, 32'h030, 32'h01234567, 0, 3, 0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h013, 32'h0,        0, 1, 1, 32'h0));
    tbl.push_back(mk(1, 0, 3, 32'h010, 32'h0,        0, 1, 1, 32'h0));
    tbl.push_back(mk(1, 1, 2, 32'h3FC, 32'hA5A55A5A, 1, 1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 32'h3FC, 32'h0,        0, 1, 0, 32'hA5A55A5A));

    sq_n = 0;
    for (int k = 0; k < NDUT; k++) begin
      rst_n[k] = 1'b0;
      drive_idle(k);
      hsize[k] = 3'd0; hburst[k] = 3'd0; hprot[k] = 4'd0; hwdata[k] = 32'h0;
    end
    #2;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d.reset.hready", k), 32'(hready[k]), 32'h1);
      check($sformatf("dut%0d.reset.hresp", k), 32'(hresp[k]), 32'h0);
      check($sformatf("dut%0d.reset.hrdata", k), hrdata[k], 32'h0);
    end
    @(negedge clk);
    rst_n = '1;
    @(posedge clk);
    #1;

    vi = 0;
    while (vi < tbl.size()) begin
      vj = vi;
      sq_n = 0;
      do begin
        push_xfer(tbl[vj].wr, 3'(tbl[vj].size), tbl[vj].addr, tbl[vj].wdata, 2'b10);
        vj++;
      end while (tbl[vj-1].b2b && vj < tbl.size());
      run_seq(tbl[vi].k);
      for (int m = 0; m < sq_n; m++) begin
        model_xfer(tbl[vi].k, sq_wr[m], sq_size[m], sq_addr[m], sq_wdata[m], dlow, dresp, drd);
        verify($sformatf("vec%0d", vi + m), m, tbl[vi+m].low, tbl[vi+m].resp, tbl[vi+m].rdata);
      end
      sq_n = 0;
      vi = vj;
    end

    // Reset asserted mid-cycle while a write sits in its wait states.
    hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b1; hsize[2] = 3'd2; haddr[2] = 32'h30;
    @(negedge clk);
    check("rstwait.accept_hready", 32'(hready[2]), 32'h1);
    @(posedge clk);
    #1;
    drive_idle(2);
    hwdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    check("rstwait.in_wait_hready", 32'(hready[2]), 32'h0);
    #1;
    rst_n[2] = 1'b0;
    #1;
    check("rstwait.hready", 32'(hready[2]), 32'h1);
    check("rstwait.hresp", 32'(hresp[2]), 32'h0);
    check("rstwait.hrdata", hrdata[2], 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(posedge clk);
    #1;
    push_xfer(1'b0, 3'd2, 32'h30, 32'h0, 2'b10);
    run_seq(2);
    verify("rstwait.readback", 0, 3, 1'b0, 32'h01234567);
    sq_n = 0;

    // Random traffic per DUT against the byte model, preceded by a known fill.
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 33; w++) begin
        push_xfer(1'b1, 3'd2, (w == 32) ? 32'h3FC : 32'(4 * w), $urandom, 2'b10);
        if (sq_n == 4 || w == 32) run_model_check(k, $sformatf("init%0d", k));
      end
      for (int it = 0; it < 30; it++) begin
        nx = $urandom_range(1, 4);
        for (int i = 0; i < nx; i++) begin
          if ($urandom_range(0, 9) == 0) raddr = 32'h3FC + $urandom_range(0, 8);
          else raddr = $urandom_range(0, 127);
          rsize = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
          push_xfer(1'($urandom), rsize, raddr, $urandom,
                    (i > 0 && $urandom_range(0, 1) == 1) ? 2'b11 : 2'b10);
        end
        run_model_check(k, $sformatf("rnd%0d_%0d", k, it));
        gsel = $urandom_range(0, 2);
        hsel[k]   = (gsel != 2);
        htrans[k] = (gsel == 0) ? 2'b00 : ((gsel == 1) ? 2'b01 : 2'b10);
        hwrite[k] = 1'($urandom);
        hsize[k]  = 3'd2;
        haddr[k]  = 32'(4 * $urandom_range(0, 31));
        @(posedge clk);
        #1;
        drive_idle(k);
        @(negedge clk);
        check($sformatf("gap%0d_%0d.hready", k, it), 32'(hready[k]), 32'h1);
        check($sformatf("gap%0d_%0d.hresp", k, it), 32'(hresp[k]), 32'h0);
        check($sformatf("gap%0d_%0d.hrdata", k, it), hrdata[k], 32'h0);
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
